// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice: instruction codes,
// register and status codes, the run-state encoding and the control bundle.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {
        RS_RESET  = 2'd0,
        RS_RUN    = 2'd1,
        RS_PAUSED = 2'd2,
        RS_HALTED = 2'd3
    } run_state_e;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic e_stall;
        logic m_stall;
        logic w_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic set_cc;
    } pipe_ctrl_t;

    // Any status that must stop architectural progress once it retires.
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == ADR) || (stat == INS) || (stat == HLT);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble generation,
// run control (pause/step/halt) and saturating performance counters.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             step,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [1:0]       run_state,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    run_state_e state_q, state_d;
    logic [2:0] final_stat_q, final_stat_d;
    logic       halted_q;

    logic       lu, rt, mp, exm, exw;
    logic       active;
    pipe_ctrl_t raw_ctrl, ctrl;

    assign lu  = ((E_icode == MRMOVQ) || (E_icode == POPQ)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt  = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
    assign mp  = (E_icode == JXX) && !e_Cnd;
    assign exm = is_exc(m_stat);
    assign exw = is_exc(W_stat);

    // A load/use hazard takes priority over ret: D must hold, so it cannot also bubble.
    always_comb begin
        raw_ctrl          = '0;
        raw_ctrl.f_stall  = lu | rt;
        raw_ctrl.d_stall  = lu;
        raw_ctrl.d_bubble = mp | (rt & ~lu);
        raw_ctrl.e_bubble = mp | lu;
        raw_ctrl.m_bubble = exm | exw;
        raw_ctrl.w_stall  = exw;
        raw_ctrl.set_cc   = (E_icode == OPQ) & ~exm & ~exw;
    end

    // Cycles in which the pipe actually advances under hazard control.
    assign active = (state_q == RS_RUN) || ((state_q == RS_PAUSED) && step);

    always_comb begin
        ctrl = '0;
        case (state_q)
            RS_RESET: begin
                ctrl.d_bubble = 1'b1;
                ctrl.e_bubble = 1'b1;
                ctrl.m_bubble = 1'b1;
            end
            RS_RUN: ctrl = raw_ctrl;
            default: begin
                if (active) begin
                    ctrl = raw_ctrl;
                end else begin
                    ctrl.f_stall = 1'b1;
                    ctrl.d_stall = 1'b1;
                    ctrl.e_stall = 1'b1;
                    ctrl.m_stall = 1'b1;
                    ctrl.w_stall = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        final_stat_d = final_stat_q;
        case (state_q)
            RS_RESET: state_d = run_en ? RS_RUN : RS_PAUSED;
            RS_RUN: begin
                if (exw) begin
                    state_d = RS_HALTED;
                end else if (!run_en) begin
                    state_d = RS_PAUSED;
                end
            end
            RS_PAUSED: begin
                if (step && exw) begin
                    state_d = RS_HALTED;
                end else if (run_en) begin
                    state_d = RS_RUN;
                end
            end
            default: state_d = RS_HALTED;
        endcase
        if ((state_d == RS_HALTED) && (state_q != RS_HALTED)) begin
            final_stat_d = W_stat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RS_RESET;
            final_stat_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            final_stat_q <= final_stat_d;
            halted_q     <= (state_d == RS_HALTED);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (active),
        .cnt (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (active & lu),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (active & mp),
        .cnt (mispred_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (active & rt & ~lu),
        .cnt (ret_cnt)
    );

    assign F_stall    = ctrl.f_stall;
    assign D_stall    = ctrl.d_stall;
    assign E_stall    = ctrl.e_stall;
    assign M_stall    = ctrl.m_stall;
    assign W_stall    = ctrl.w_stall;
    assign D_bubble   = ctrl.d_bubble;
    assign E_bubble   = ctrl.e_bubble;
    assign M_bubble   = ctrl.m_bubble;
    assign set_cc     = ctrl.set_cc;
    assign run_state  = state_q;
    assign halted     = halted_q;
    assign final_stat = final_stat_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 32-bit and a 4-bit counter instance share stimulus
// and are compared against a rule-level model, a vector table and directed sequences.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, run_en, step, e_cnd;
    logic [3:0] d_icode, d_src_a, d_src_b, e_icode, e_dstm, m_icode;
    logic [2:0] m_stat, w_stat;

    logic        f32, d32, e32, m32, w32, db32, eb32, mb32, cc32, h32;
    logic [1:0]  rs32;
    logic [2:0]  fs32;
    logic [31:0] cyc32, stall32, mp32, ret32;

    logic        f4, d4, e4, m4, w4, db4, eb4, mb4, cc4, h4;
    logic [1:0]  rs4;
    logic [2:0]  fs4;
    logic [3:0]  cyc4, stall4, mp4, ret4;

    logic [8:0] ctrl32, ctrl4;
    assign ctrl32 = {f32, d32, e32, m32, w32, db32, eb32, mb32, cc32};
    assign ctrl4  = {f4, d4, e4, m4, w4, db4, eb4, mb4, cc4};

    pipe_hazard_ctrl #(.CNT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .step(step),
        .D_icode(d_icode), .d_srcA(d_src_a), .d_srcB(d_src_b),
        .E_icode(e_icode), .E_dstM(e_dstm), .e_Cnd(e_cnd),
        .M_icode(m_icode), .m_stat(m_stat), .W_stat(w_stat),
        .F_stall(f32), .D_stall(d32), .E_stall(e32), .M_stall(m32), .W_stall(w32),
        .D_bubble(db32), .E_bubble(eb32), .M_bubble(mb32), .set_cc(cc32),
        .run_state(rs32), .halted(h32), .final_stat(fs32),
        .cyc_cnt(cyc32), .stall_cnt(stall32), .mispred_cnt(mp32), .ret_cnt(ret32)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .step(step),
        .D_icode(d_icode), .d_srcA(d_src_a), .d_srcB(d_src_b),
        .E_icode(e_icode), .E_dstM(e_dstm), .e_Cnd(e_cnd),
        .M_icode(m_icode), .m_stat(m_stat), .W_stat(w_stat),
        .F_stall(f4), .D_stall(d4), .E_stall(e4), .M_stall(m4), .W_stall(w4),
        .D_bubble(db4), .E_bubble(eb4), .M_bubble(mb4), .set_cc(cc4),
        .run_state(rs4), .halted(h4), .final_stat(fs4),
        .cyc_cnt(cyc4), .stall_cnt(stall4), .mispred_cnt(mp4), .ret_cnt(ret4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state 0=reset 1=run 2=paused 3=halted, counters as plain integers.
    int          m_st;
    logic [2:0]  m_fstat;
    int unsigned m_cyc, m_stall, m_mp, m_ret;

    function automatic logic [4:0] terms();
        logic lu, rt, mp, exm, exw;
        lu  = (e_icode == 4'h5 || e_icode == 4'hB) && e_dstm != 4'hF &&
              (e_dstm == d_src_a || e_dstm == d_src_b);
        rt  = (d_icode == 4'h9) || (e_icode == 4'h9) || (m_icode == 4'h9);
        mp  = (e_icode == 4'h7) && !e_cnd;
        exm = (m_stat >= 3'd2) && (m_stat <= 3'd4);
        exw = (w_stat >= 3'd2) && (w_stat <= 3'd4);
        return {lu, rt, mp, exm, exw};
    endfunction

    function automatic logic [8:0] model_ctrl();
        logic lu, rt, mp, exm, exw;
        {lu, rt, mp, exm, exw} = terms();
        if (m_st == 0) return 9'b00000_111_0;
        if (m_st == 3 || (m_st == 2 && !step)) return 9'b11111_000_0;
        return {lu | rt, lu, 1'b0, 1'b0, exw, mp | (rt & !lu), mp | lu, exm | exw,
                (e_icode == 4'h6) & !exm & !exw};
    endfunction

    task automatic model_advance();
        logic lu, rt, mp, exm, exw;
        bit   act;
        {lu, rt, mp, exm, exw} = terms();
        act = 0;
        if (!rst_n) begin
            m_st = 0; m_fstat = 3'd0;
            m_cyc = 0; m_stall = 0; m_mp = 0; m_ret = 0;
            return;
        end
        case (m_st)
            0: m_st = run_en ? 1 : 2;
            1: begin
                act = 1;
                if (exw) begin m_st = 3; m_fstat = w_stat; end
                else if (!run_en) m_st = 2;
            end
            2: begin
                if (step) act = 1;
                if (step && exw) begin m_st = 3; m_fstat = w_stat; end
                else if (run_en) m_st = 1;
            end
            default: ;
        endcase
        if (act) begin
            m_cyc++;
            if (lu) m_stall++;
            if (mp) m_mp++;
            if (rt && !lu) m_ret++;
        end
    endtask

    function automatic logic [31:0] sat4(input int unsigned v);
        return (v > 15) ? 32'd15 : v;
    endfunction

    task automatic chk_regs();
        chk("run_state", rs32, m_st);
        chk("halted", h32, m_st == 3);
        chk("final_stat", fs32, m_fstat);
        chk("cyc_cnt", cyc32, m_cyc);
        chk("stall_cnt", stall32, m_stall);
        chk("mispred_cnt", mp32, m_mp);
        chk("ret_cnt", ret32, m_ret);
        chk("run_state_w4", rs4, m_st);
        chk("cyc_cnt_w4", cyc4, sat4(m_cyc));
        chk("stall_cnt_w4", stall4, sat4(m_stall));
        chk("mispred_cnt_w4", mp4, sat4(m_mp));
        chk("ret_cnt_w4", ret4, sat4(m_ret));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic run_cycle();
        #1;
        chk("ctrl", ctrl32, model_ctrl());
        chk("ctrl_w4", ctrl4, model_ctrl());
        model_advance();
        @(posedge clk);
        #1;
        chk_regs();
        @(negedge clk);
    endtask

    task automatic set_idle();
        step = 0; d_icode = 4'h1; d_src_a = 4'hF; d_src_b = 4'hF;
        e_icode = 4'h1; e_dstm = 4'hF; e_cnd = 1; m_icode = 4'h1;
        m_stat = 3'd1; w_stat = 3'd1;
    endtask

    task automatic set_lu();
        e_icode = 4'h5; e_dstm = 4'h3; d_src_a = 4'h3;
    endtask

    typedef struct {
        logic [3:0] d_icode, src_a, src_b, e_icode, e_dstm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [2:0] m_stat;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[13];
    logic [3:0] ic_pool[8];
    logic [31:0] base;

    initial begin
        // order of exp: F D E M W stalls, D E M bubbles, set_cc
        tbl[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 9'b00000_000_0};
        tbl[1]  = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 9'b11000_010_0};
        tbl[2]  = '{4'h1, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 9'b11000_010_0};
        tbl[3]  = '{4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 9'b00000_000_0};
        tbl[4]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 9'b10000_100_0};
        tbl[5]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 9'b00000_110_0};
        tbl[6]  = '{4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 9'b10000_110_0};
        tbl[7]  = '{4'h9, 4'h4, 4'hF, 4'h5, 4'h4, 1'b1, 4'h1, 3'd1, 9'b11000_010_0};
        tbl[8]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 9'b00000_000_1};
        tbl[9]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 9'b00000_001_0};
        tbl[10] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 9'b00000_000_0};
        tbl[11] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd4, 9'b10000_101_0};
        tbl[12] = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd2, 9'b00000_001_0};
        ic_pool = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2, 4'h0};

        set_idle();
        rst_n = 0; run_en = 1;
        repeat (2) @(posedge clk);
        m_st = 0; m_fstat = 3'd0; m_cyc = 0; m_stall = 0; m_mp = 0; m_ret = 0;
        @(negedge clk);

        // Reset state
        #1;
        chk("rst_ctrl", ctrl32, 9'b00000_111_0);
        chk("rst_state", rs32, 0);
        chk("rst_cyc", cyc32, 0);
        chk("rst_final_stat", fs32, 0);
        run_cycle();
        rst_n = 1;
        run_cycle();
        chk("reset_to_run", rs32, 1);

        // Vector table, applied in RUN
        for (int i = 0; i < 13; i++) begin
            d_icode = tbl[i].d_icode; d_src_a = tbl[i].src_a; d_src_b = tbl[i].src_b;
            e_icode = tbl[i].e_icode; e_dstm = tbl[i].e_dstm; e_cnd = tbl[i].cnd;
            m_icode = tbl[i].m_icode; m_stat = tbl[i].m_stat;
            #1;
            chk($sformatf("tbl%0d", i), ctrl32, tbl[i].exp);
            run_cycle();
        end

        // Load/use
        set_idle(); set_lu();
        base = stall32;
        run_cycle();
        chk("lu_stall_cnt_inc", stall32, base + 1);

        // Ret in D for three cycles
        set_idle(); d_icode = 4'h9;
        base = ret32;
        repeat (3) begin
            #1;
            chk("ret_f_stall", f32, 1);
            chk("ret_d_bubble", db32, 1);
            run_cycle();
        end
        chk("ret_cnt_plus3", ret32, base + 3);

        // Mispredict with ret in D
        set_idle(); e_icode = 4'h7; e_cnd = 0; d_icode = 4'h9;
        base = mp32;
        #1;
        chk("mp_ret_ctrl", ctrl32, 9'b10000_110_0);
        run_cycle();
        chk("mispred_cnt_inc", mp32, base + 1);

        // Pause with one step carrying a load/use hazard
        set_idle(); run_en = 0;
        run_cycle();
        base = cyc32;
        for (int k = 0; k < 5; k++) begin
            set_idle();
            step = (k == 2);
            set_lu();
            #1;
            chk("pause_d_stall", d32, 1);
            chk("pause_e_bubble", eb32, (k == 2));
            chk("pause_f_stall", f32, 1);
            run_cycle();
        end
        chk("pause_cyc_plus1", cyc32, base + 1);
        chk("still_paused", rs32, 2);
        set_idle(); run_en = 1;
        run_cycle();
        chk("resume_run", rs32, 1);

        // Saturation on the 4-bit instance, then mid-run reset
        repeat (20) run_cycle();
        chk("cyc_w4_saturated", cyc4, 4'hF);
        chk("cyc32_ge_16", cyc32 >= 32'd16, 1);
        rst_n = 0;
        run_cycle();
        chk("midrst_cyc", cyc32, 0);
        chk("midrst_state", rs32, 0);
        rst_n = 1;
        #1;
        chk("midrst_flush_ctrl", ctrl32, 9'b00000_111_0);
        run_cycle();
        chk("midrst_run", rs32, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n   = ($urandom_range(0, 29) != 0);
            run_en  = ($urandom_range(0, 3) != 0);
            step    = ($urandom_range(0, 3) == 0);
            d_icode = ic_pool[$urandom_range(0, 7)];
            e_icode = ic_pool[$urandom_range(0, 7)];
            m_icode = ic_pool[$urandom_range(0, 7)];
            d_src_a = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(2, 4));
            d_src_b = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(2, 4));
            e_dstm  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(2, 4));
            e_cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            w_stat  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            run_cycle();
        end

        // Exception reaching M then W
        set_idle(); run_en = 1; rst_n = 0;
        run_cycle();
        rst_n = 1;
        run_cycle();
        m_stat = 3'd3; e_icode = 4'h6;
        #1;
        chk("exm_m_bubble", mb32, 1);
        chk("exm_set_cc", cc32, 0);
        run_cycle();
        set_idle(); w_stat = 3'd3;
        #1;
        chk("exw_w_stall", w32, 1);
        run_cycle();
        chk("halted_state", rs32, 3);
        chk("halted_flag", h32, 1);
        chk("halted_final_stat", fs32, 3);
        base = cyc32;
        set_idle(); set_lu();
        repeat (3) begin
            #1;
            chk("halted_ctrl", ctrl32, 9'b11111_000_0);
            run_cycle();
        end
        chk("halted_cyc_frozen", cyc32, base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline: drives per-stage stall/bubble controls for the F, D, E, M and W pipeline registers, and the condition-code write enable.
- Resolves load/use, ret and mispredicted-branch hazards, and freezes the pipe when an exception or halt reaches the W stage.
- Adds run control (pause/single-step), a run-state FSM and saturating performance counters.
- Sits beside the pipeline registers; reads stage fields and drives their control inputs.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- run_en  in  1  1 = free-run; 0 = pause.
- step  in  1  one-cycle pulse; while paused, advances the pipe by one cycle.
- D_icode  in  4  icode in the D register.
- d_srcA, d_srcB  in  4  source registers decoded in D (0xF = none).
- E_icode  in  4  icode in the E register.
- E_dstM  in  4  dstM in the E register.
- e_Cnd  in  1  branch condition computed in E.
- M_icode  in  4  icode in the M register.
- m_stat  in  3  status out of the memory stage.
- W_stat  in  3  status in the W register.
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1  hold the register.
- D_bubble, E_bubble, M_bubble  out  1  load a nop bubble.
- set_cc  out  1  condition-code write enable.
- run_state  out  2  FSM state.
- halted  out  1  run_state == HALTED.
- final_stat  out  3  W_stat captured on entry to HALTED.
- cyc_cnt, stall_cnt, mispred_cnt, ret_cnt  out  CNT_W  performance counters.

Behaviour:
- Hazard terms (combinational):
  - lu = E_icode in {MRMOVQ, POPQ} && E_dstM != RNONE && E_dstM in {d_srcA, d_srcB}.
  - rt = RET in {D_icode, E_icode, M_icode}.
  - mp = E_icode == JXX && !e_Cnd.
  - exm = m_stat in {ADR, INS, HLT}.
  - exw = W_stat in {ADR, INS, HLT}.
- Raw controls (RUN):
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exm | exw.
  - W_stall = exw.
  - E_stall = M_stall = 0.
  - set_cc = E_icode == OPQ & !exm & !exw.
- Gating (frozen = PAUSED without step, or HALTED): all five stalls = 1, all bubbles = 0, set_cc = 0.
- Invariant: Xx_stall and Xx_bubble are never both 1 for the same stage. lu with rt gives D stall + E bubble; mp with rt gives D and E bubble.
- All controls are same-cycle combinational; state and counters are registered on clk.
- FSM states: RESET=0, RUN=1, PAUSED=2, HALTED=3.
  - RESET -> RUN after one cycle if run_en, else -> PAUSED.
  - RUN: exw -> HALTED; else !run_en -> PAUSED.
  - PAUSED: run_en -> RUN. A step pulse gives one RUN-gated cycle and the state stays PAUSED. If exw is present during a step cycle -> HALTED.
  - HALTED is absorbing until reset. final_stat is loaded with W_stat on the entry cycle.
- Counters increment only on non-frozen cycles and saturate at all-ones, no wrap:
  - cyc_cnt: every non-frozen cycle.
  - stall_cnt: +1 when lu.
  - mispred_cnt: +1 when mp.
  - ret_cnt: +1 when rt & !lu.
- Reset (rst_n low at clk, including mid-run): state=RESET, counters=0, final_stat=0. The RESET state drives all stalls=0, D/E/M bubbles=1, set_cc=0 so the pipe flushes.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants HALT..POPQ (0x0..0xB), JXX=7, RET=9, OPQ=6, MRMOVQ=5, POPQ=0xB.
  - RNONE=0xF.
  - stat codes AOK=1, HLT=2, ADR=3, INS=4.
  - run_state encoding.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated four times.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3, run_en=1 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt 0->1.
- Ret: D_icode=9 for 3 cycles (no lu) -> F_stall=1 and D_bubble=1 each cycle; ret_cnt=3.
- Mispredict with ret in D: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=E_bubble=1, F_stall=1; mispred_cnt+1.
- Exception:
  - m_stat=ADR, E_icode=6 -> M_bubble=1, set_cc=0.
  - Next cycle W_stat=ADR -> W_stall=1, state HALTED, final_stat=3, all stalls=1, counters frozen.
- Pause/step: run_en=0 for 5 cycles with one step pulse -> cyc_cnt +1 only; lu asserted during step gives D_stall=1, E_bubble=1 for that cycle only.
- Reset mid-run, then counter saturation:
  - Counters 0x10, rst_n=0 one cycle -> counters 0, RESET bubbles asserted, then RUN.
  - With CNT_W=4, 20 run cycles -> cyc_cnt holds 0xF.
